ldpc_llr_loader: RTL and testbench

//  Writer side of the LLR RAM interface read by the 36-lane VPU array.
//  - Accepts a serial stream of signed channel LLRs and saturates each to Width_R.
//  - Fills one 9216-sample codeword, column-major: lane = n/256, addr = n%256.
//  - Storage is ping-pong (2 banks), so the decoder reads one bank while the next frame loads.
//  - Hands each full bank to the decoder through a ready/done handshake.

---
 rtl/ldpc_pkg.sv | 16 +
 rtl/ldpc_llr_sat.sv | 38 +++
 rtl/ldpc_llr_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_ldpc_llr_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants and state encoding for the LDPC LLR loader.
package ldpc_pkg;

    localparam int LANES     = 36;
    localparam int DEPTH     = 256;
    localparam int FRAME_LEN = LANES * DEPTH;
    localparam int Width_R   = 7;
    localparam int Width_A   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/ldpc_llr_sat.sv
// Symmetric saturator from Width_IN to Width_R signed; -2^(Width_R-1) is never produced.
// The sat flag port exists only when LDPC_LLR_SATCNT_EN is defined.
module ldpc_llr_sat
    import ldpc_pkg::*;
#(
    parameter int Width_IN = 8,
    parameter int Width_R  = ldpc_pkg::Width_R
) (
    input  logic [Width_IN-1:0] din,
    output logic [Width_R-1:0]  dout
`ifdef LDPC_LLR_SATCNT_EN
    ,
    output logic                sat
`endif
);

    localparam int SatMax = (1 << (Width_R - 1)) - 1;
    localparam int SatMin = -SatMax;
    localparam logic [Width_R-1:0] PosLim = SatMax[Width_R-1:0];
    localparam logic [Width_R-1:0] NegLim = SatMin[Width_R-1:0];

    int value;

    always_comb begin
        value = int'($signed(din));
        dout  = din[Width_R-1:0];
        if (value > SatMax) begin
            dout = PosLim;
        end else if (value < SatMin) begin
            dout = NegLim;
        end
    end

`ifdef LDPC_LLR_SATCNT_EN
    assign sat = (value > SatMax) || (value < SatMin);
`endif

endmodule

// File: rtl/ldpc_llr_loader.sv
// LLR RAM writer for the VPU array: saturates a serial LLR stream into ping-pong banks,
// column-major. Define LDPC_LLR_SATCNT_EN to add the per-frame sat_cnt output.
module ldpc_llr_loader
    import ldpc_pkg::*;
#(
    parameter int Width_IN = 8,
    parameter int Width_R  = ldpc_pkg::Width_R,
    parameter int Width_A  = ldpc_pkg::Width_A,
    parameter int LANES    = ldpc_pkg::LANES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Width_IN-1:0] llr_din,
    input  logic                llr_valid,
    input  logic                llr_sof,
    output logic                llr_ready,
    output logic [LANES-1:0]    lram_wren,
    output logic [Width_A:0]    lram_waddr,
    output logic [Width_R-1:0]  lram_wdata,
    output logic                frame_rdy,
    output logic                frame_bank,
    input  logic                dec_done,
    output logic                sof_err
`ifdef LDPC_LLR_SATCNT_EN
    ,
    output logic [13:0]         sat_cnt
`endif
);

    localparam int LaneW = $clog2(LANES);
    localparam logic [LaneW-1:0]   LastLane = LaneW'(LANES - 1);
    localparam logic [Width_A-1:0] LastAddr = '1;
    localparam logic [Width_A-1:0] AddrOne  = Width_A'(1);
    localparam logic [LANES-1:0]   LaneOne  = LANES'(1);

    state_e state_q, state_d;
    logic [LaneW-1:0]   lane_q, lane_d;
    logic [Width_A-1:0] addr_q, addr_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [1:0]         bank_full_q, bank_full_d;

    logic               accept, release_bank, last_sample, other_full;
    logic               wr_en, restart, frame_end;
    logic [LaneW-1:0]   wr_lane;
    logic [Width_A-1:0] wr_addr;

    logic [LANES-1:0]   wren_q;
    logic [Width_A:0]   waddr_q;
    logic [Width_R-1:0] wdata_q;
    logic               sof_err_q;
    // Last write of a frame is in flight; bank_full is set one cycle after it lands.
    logic               done_q, done_bank_q;

    logic [Width_R-1:0] sat_val;
`ifdef LDPC_LLR_SATCNT_EN
    logic               sat_flag;
    logic [13:0]        run_cnt_q, sat_cnt_q;
`endif

    ldpc_llr_sat #(
        .Width_IN(Width_IN),
        .Width_R (Width_R)
    ) u_sat (
        .din (llr_din),
        .dout(sat_val)
`ifdef LDPC_LLR_SATCNT_EN
        ,
        .sat (sat_flag)
`endif
    );

    assign accept       = llr_valid & llr_ready;
    assign release_bank = dec_done & frame_rdy;
    assign last_sample  = (lane_q == LastLane) && (addr_q == LastAddr);
    // A release this cycle of the other bank frees it for the next frame.
    assign other_full   = bank_full_q[~wr_bank_q] &
                          ~(release_bank & (rd_bank_q != wr_bank_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wr_bank_d = wr_bank_q;
        wr_en     = 1'b0;
        wr_lane   = lane_q;
        wr_addr   = addr_q;
        restart   = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && llr_sof) begin
                    wr_en   = 1'b1;
                    wr_lane = '0;
                    wr_addr = '0;
                    lane_d  = '0;
                    addr_d  = AddrOne;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (llr_sof) begin
                        restart = 1'b1;
                        wr_lane = '0;
                        wr_addr = '0;
                        lane_d  = '0;
                        addr_d  = AddrOne;
                    end else if (last_sample) begin
                        frame_end = 1'b1;
                        lane_d    = '0;
                        addr_d    = '0;
                        wr_bank_d = ~wr_bank_q;
                        state_d   = other_full ? S_WAIT : S_IDLE;
                    end else begin
                        addr_d = addr_q + AddrOne;
                        if (addr_q == LastAddr) begin
                            lane_d = lane_q + 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (release_bank) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        llr_ready  = (state_q != S_WAIT);
        frame_rdy  = |bank_full_q;
        frame_bank = rd_bank_q;
    end

    always_comb begin
        bank_full_d = bank_full_q;
        rd_bank_d   = rd_bank_q;
        if (release_bank) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
        if (done_q) begin
            bank_full_d[done_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q      <= '0;
            addr_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
        end else begin
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wren_q      <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            sof_err_q   <= 1'b0;
            done_q      <= 1'b0;
            done_bank_q <= 1'b0;
        end else begin
            wren_q      <= wr_en ? (LaneOne << wr_lane) : '0;
            sof_err_q   <= restart;
            done_q      <= frame_end;
            done_bank_q <= wr_bank_q;
            if (wr_en) begin
                waddr_q <= {wr_bank_q, wr_addr};
                wdata_q <= sat_val;
            end
        end
    end

`ifdef LDPC_LLR_SATCNT_EN
    // n=0 writes happen only on sof, so they restart the running count.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            if (wr_en && (wr_lane == '0) && (wr_addr == '0)) begin
                run_cnt_q <= 14'(sat_flag);
            end else if (wr_en) begin
                run_cnt_q <= run_cnt_q + 14'(sat_flag);
            end
            if (done_q) begin
                sat_cnt_q <= run_cnt_q;
            end
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

    assign lram_wren  = wren_q;
    assign lram_waddr = waddr_q;
    assign lram_wdata = wdata_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Bench for ldpc_llr_loader: saturation table, directed frame sequences and a random phase,
// all checked every cycle against a queue-based model of banks and frames.
module tb_ldpc_llr_loader;

    localparam int FrameLen = 9216;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  llr_din;
    logic        llr_valid;
    logic        llr_sof;
    logic        llr_ready;
    logic [35:0] lram_wren;
    logic [8:0]  lram_waddr;
    logic [6:0]  lram_wdata;
    logic        frame_rdy;
    logic        frame_bank;
    logic        dec_done;
    logic        sof_err;
`ifdef LDPC_LLR_SATCNT_EN
    logic [13:0] sat_cnt;
`endif

    ldpc_llr_loader dut (
        .clk       (clk),
        .reset     (reset),
        .llr_din   (llr_din),
        .llr_valid (llr_valid),
        .llr_sof   (llr_sof),
        .llr_ready (llr_ready),
        .lram_wren (lram_wren),
        .lram_waddr(lram_waddr),
        .lram_wdata(lram_wdata),
        .frame_rdy (frame_rdy),
        .frame_bank(frame_bank),
        .dec_done  (dec_done),
        .sof_err   (sof_err)
`ifdef LDPC_LLR_SATCNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: frames fill banks in alternation; full_q lists full banks, oldest first.
    int          full_q[$];
    int          m_n, m_rel, m_pend, m_pend_sat, m_run_sat, m_sat_cnt;
    bit          m_loading, m_blocked, m_wr_bank;
    logic [35:0] e_wren;
    logic [8:0]  e_waddr;
    logic [6:0]  e_wdata;
    bit          e_sof_err;

    typedef struct {
        logic [7:0] din;
        logic [6:0] wdata;
    } sat_vec_t;

    sat_vec_t tbl[11];

    function automatic int sat63(int v);
        if (v > 63) return 63;
        if (v < -63) return -63;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        full_q.delete();
        m_n = 0; m_rel = 0; m_pend = -1; m_pend_sat = 0; m_run_sat = 0; m_sat_cnt = 0;
        m_loading = 0; m_blocked = 0; m_wr_bank = 0;
        e_wren = '0; e_waddr = '0; e_wdata = '0; e_sof_err = 0;
    endtask

    task automatic model_update(input bit rst, input bit v, input bit s, input logic [7:0] d,
                                input bit dn);
        bit rel, acc, was_blocked;
        int n, sv, ws;
        if (rst) begin
            model_reset();
            return;
        end
        rel         = dn && (full_q.size() != 0);
        acc         = v && !m_blocked;
        was_blocked = m_blocked;
        e_wren      = '0;
        e_sof_err   = 0;
        if (rel) begin
            void'(full_q.pop_front());
            m_rel++;
        end
        if (m_pend >= 0) begin
            full_q.push_back(m_pend);
            m_sat_cnt = m_pend_sat;
            m_pend    = -1;
        end
        if (was_blocked && rel) m_blocked = 0;
        if (acc && (s || m_loading)) begin
            if (s) begin
                e_sof_err = m_loading;
                n         = 0;
                m_run_sat = 0;
            end else begin
                n = m_n;
            end
            sv = int'($signed(d));
            ws = sat63(sv);
            if (ws != sv) m_run_sat++;
            e_wren    = 36'd1 << (n / 256);
            e_waddr   = {m_wr_bank, 8'(n % 256)};
            e_wdata   = 7'(ws);
            m_loading = 1;
            m_n       = n + 1;
            if (n == FrameLen - 1) begin
                m_pend     = m_wr_bank;
                m_pend_sat = m_run_sat;
                m_wr_bank  = !m_wr_bank;
                m_loading  = 0;
                m_n        = 0;
                m_blocked  = (full_q.size() != 0);
            end
        end
    endtask

    task automatic cmp_cycle();
        logic [63:0] act, exp, mask;
        int fb;
        fb   = (full_q.size() != 0) ? full_q[0] : (m_rel % 2);
        exp  = {8'b0, !m_blocked, (full_q.size() != 0), fb[0], e_sof_err, e_wren, e_waddr,
                e_wdata};
        act  = {8'b0, llr_ready, frame_rdy, frame_bank, sof_err, lram_wren, lram_waddr,
                lram_wdata};
        // Address and data are only meaningful while a write is strobed.
        mask = (e_wren != '0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_0000;
        check("cycle", act & mask, exp & mask);
`ifdef LDPC_LLR_SATCNT_EN
        check("sat_cnt", sat_cnt, m_sat_cnt);
`endif
    endtask

    task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] d,
                        input bit dn);
        reset     = rst;
        llr_valid = v;
        llr_sof   = s;
        llr_din   = d;
        dec_done  = dn;
        @(posedge clk);
        model_update(rst, v, s, d, dn);
        #1;
        cmp_cycle();
    endtask

    task automatic feed(input int first, input int count, input bit sof_first,
                        input bit done_last);
        for (int i = 0; i < count; i++) begin
            int n;
            n = first + i;
            step(0, 1, sof_first && (i == 0), 8'(n % 128 - 64), done_last && (i == count - 1));
        end
    endtask

    initial begin
        bit          rv, rs, rd;
        logic [7:0]  rdin;

        tbl[0]  = '{8'd100, 7'h3f};
        tbl[1]  = '{8'h80,  7'h41};
        tbl[2]  = '{8'd5,   7'h05};
        tbl[3]  = '{8'd63,  7'h3f};
        tbl[4]  = '{8'd64,  7'h3f};
        tbl[5]  = '{8'hC1,  7'h41};
        tbl[6]  = '{8'hC0,  7'h41};
        tbl[7]  = '{8'h00,  7'h00};
        tbl[8]  = '{8'hFF,  7'h7f};
        tbl[9]  = '{8'd127, 7'h3f};
        tbl[10] = '{8'hC2,  7'h42};

        model_reset();
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        check("rst_ready", llr_ready, 1);
        check("rst_wren", lram_wren, 0);
        check("rst_waddr", lram_waddr, 0);
        check("rst_frame_rdy", frame_rdy, 0);
        check("rst_frame_bank", frame_bank, 0);
        check("rst_sof_err", sof_err, 0);

        // Saturation table, written as the start of a frame.
        for (int i = 0; i < 11; i++) begin
            step(0, 1, (i == 0), tbl[i].din, 0);
            check("sat_wdata", lram_wdata, tbl[i].wdata);
            check("sat_waddr", lram_waddr, 9'(i));
        end

        // Full frame into bank 0.
        step(1, 0, 0, 8'h00, 0);
        feed(0, FrameLen, 1, 0);
        check("last_wren", lram_wren, 36'h8_0000_0000);
        check("last_waddr", lram_waddr, 9'h0ff);
        check("frame_rdy_lag", frame_rdy, 0);
        step(0, 0, 0, 8'h00, 0);
        check("frame1_rdy", frame_rdy, 1);
        check("frame1_bank", frame_bank, 0);

        // Second frame fills bank 1 and the loader stalls.
        feed(0, FrameLen, 1, 0);
        check("wait_ready", llr_ready, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h11, 0);
        check("wait_no_write", lram_wren, 0);
        step(0, 0, 0, 8'h00, 1);
        check("release_bank", frame_bank, 1);
        check("release_ready", llr_ready, 1);

        // Restart at n=1000 of a bank-0 frame.
        feed(0, 1000, 1, 0);
        step(0, 1, 1, 8'd7, 0);
        check("restart_sof_err", sof_err, 1);
        check("restart_wren", lram_wren, 1);
        check("restart_waddr", lram_waddr, 0);
        feed(1, FrameLen - 1, 0, 0);
        step(0, 0, 0, 8'h00, 0);
        check("restart_done_rdy", frame_rdy, 1);
        check("restart_done_bank", frame_bank, 1);
        check("restart_done_ready", llr_ready, 0);
        step(0, 0, 0, 8'h00, 1);
        check("free_bank1", frame_bank, 0);

        // dec_done on the same cycle as the last accept of the bank-1 frame.
        feed(0, FrameLen, 1, 1);
        step(0, 0, 0, 8'h00, 0);
        check("same_cycle_rdy", frame_rdy, 1);
        check("same_cycle_bank", frame_bank, 1);
        check("same_cycle_ready", llr_ready, 1);
        step(0, 0, 0, 8'h00, 1);

        // Reset mid-frame, then a stream without sof.
        feed(0, 5000, 1, 0);
        step(1, 1, 0, 8'd9, 0);
        check("midrst_wren", lram_wren, 0);
        check("midrst_rdy", frame_rdy, 0);
        for (int i = 0; i < 100; i++) step(0, 1, 0, 8'($urandom), 0);
        check("nosof_wren", lram_wren, 0);
        check("nosof_rdy", frame_rdy, 0);

        // Random traffic.
        for (int c = 0; c < 25000; c++) begin
            rv   = ($urandom_range(0, 9) != 0);
            rs   = m_loading ? ($urandom_range(0, 19999) == 0) : ($urandom_range(0, 19) == 0);
            rd   = ($urandom_range(0, 799) == 0);
            rdin = 8'($urandom);
            step(0, rv, rs, rdin, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
